sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the single 16-bit combined_ram between two requesters: port 0 (PUF readout FSM) and port 1 (test-pattern writer / debug access).
- Accepts at most one command per cycle and registers it onto the RAM ports.
- Returns read data to the originating port with a fixed latency.
- Uses round-robin priority, with optional locked bursts capped at MAX_BURST grants.

Parameters:
- ADDR_W, 13, RAM word address width (8192 x 16-bit words).
- DATA_W, 16, RAM word width.
- MAX_BURST, 8, maximum consecutive locked grants to one port while the other port is requesting; range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  command request, port 0 / 1
- lock0 / lock1  in  1  request to keep ownership across consecutive commands
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- wmask0 / wmask1  in  DATA_W  bit mask; bit = 1 means that bit is NOT written; 0 writes all bits
- gnt0 / gnt1  out  1  command accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  read data valid for the port
- rdata0 / rdata1  out  DATA_W  read data; both equal ram_rdata, qualified by rvalidN
- ram_raddr  out  ADDR_W  RAM read address (registered)
- ram_waddr  out  ADDR_W  RAM write address (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_wdata  out  DATA_W  RAM write data (registered)
- ram_wmask  out  DATA_W  RAM write mask (registered)
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_raddr is sampled

Behaviour:
- Handshake:
  - Requester holds reqN and the command fields stable until gntN=1.
  - The command is accepted in the cycle where reqN && gntN.
  - At most one of gnt0/gnt1 is high in any cycle.
  - gntN is never high without reqN.
- Pipeline for a command accepted in cycle T:
  - ram_* are driven from registers in cycle T+1.
  - For a read, rvalidN=1 in cycle T+2, with rdataN = ram_rdata.
  - For a write, no rvalid is produced.
  - Back-to-back accepts give one command per cycle, so throughput is 1/cycle.
- Idle RAM cycles (no accept in T): ram_we=0 in T+1. raddr, waddr, wdata and wmask hold their previous values.
- Read-return tag: 2-stage shift of {valid, port}. Each rvalidN is a one-cycle pulse per accepted read.
- FSM states: IDLE, OWN0, OWN1. A 16-bit burst counter tracks consecutive grants to the current owner.
- IDLE:
  - If only one port requests, grant it.
  - If both request, grant the round-robin winner: the port not granted last. After reset port 0 wins.
  - On a grant with lockN=1: go to OWNN, counter=1.
  - Otherwise stay in IDLE and flip the round-robin pointer to favour the other port.
- OWNN:
  - reqN=1 and (counter < MAX_BURST or other port idle): grant N, counter+1 (saturating).
  - reqN=0 or lockN=0: release to IDLE. The arbitration in that same cycle is performed as in IDLE, so no bubble.
  - counter == MAX_BURST and the other port is requesting: grant the other port this cycle and set the round-robin pointer to favour N next.
    - If the other port's lock=1, go to OWN(other) with counter=1.
    - Otherwise go to IDLE.
- Simultaneous events:
  - Reads and writes from either port are treated identically.
  - A read following a write to the same address in the next cycle returns the new data; combined_ram handles this, and the arbiter preserves order.
- Reset: all of the following are 0 after the rst cycle: gnt0/1, rvalid0/1, ram_we, ram_raddr, ram_waddr, ram_wdata, ram_wmask, counter, round-robin pointer; FSM goes to IDLE.
- Reset mid-operation: in-flight reads are dropped and no rvalid appears after rst. A write registered but not yet applied when rst is sampled is cancelled (ram_we forced 0).
- Width rules: the counter saturates at its max value and never wraps. Addresses pass through unmodified; no address arithmetic.

Test Plan:
- Single read: after reset, req0=1, we0=0, addr0=0x0005 for 1 cycle → gnt0=1 in T, ram_raddr=0x0005 at T+1, rvalid0=1 with rdata0=RAM[5] at T+2, rvalid1=0 throughout.
- Contention round-robin: req0=req1=1 with lock=0, reads of 0x10 and 0x20 for 4 cycles → grants alternate 0,1,0,1; rvalid alternates two cycles later with matching data.
- Locked burst cap: MAX_BURST=8; lock0=req0=1 continuously, req1=1 from cycle 2 → port 0 gets 8 consecutive grants, then gnt1=1 for one cycle, then port 0 resumes.
- Write then read: port 1 writes 0xBEEF to 0x1FFF with wmask=0, next cycle reads 0x1FFF → ram_we=1 exactly one cycle, rdata1=0xBEEF with rvalid1.
- Masked write: RAM[0x3]=0xFFFF; write 0x0000 with wmask=0xFF00, then read → 0xFF00.
- Reset mid-read: accept a read at T, assert rst at T+1 → no rvalid at T+2. All outputs are 0, FSM is IDLE, and the next contended grant goes to port 0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//
// Purpose:
//   Shares the single-ported (one read + one write address) combined_ram
//   between two requesters. Port 0 is the PUF readout FSM, port 1 is the
//   test-pattern writer / debug access. At most one command is accepted per
//   cycle and is registered onto the RAM ports. Read data is returned to
//   the originating port exactly two cycles after the command is accepted.
//   Arbitration is round-robin. A port may hold ownership across consecutive
//   commands using its lock input; the lock is capped at MAX_BURST grants
//   while the other port is waiting.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req0/1, lock0/1          command request, keep-ownership request
//   we0/1                    1 = write, 0 = read
//   addr0/1, wdata0/1        word address, write data
//   wmask0/1                 write mask, a 1 bit is left unchanged in RAM
//   gnt0/1                   command accepted this cycle (combinational)
//   rvalid0/1, rdata0/1      read return, rdata is ram_rdata qualified by rvalid
//   ram_raddr, ram_waddr     registered RAM addresses
//   ram_we, ram_wdata,       registered RAM write controls
//   ram_wmask
//   ram_rdata                RAM read data, one cycle after ram_raddr
// ---------------------------------------------------------------------------
module sram_port_arbiter #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0,
    input  logic              lock0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wmask0,

    input  logic              req1,
    input  logic              lock1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] wmask1,

    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,

    output logic [ADDR_W-1:0] ram_raddr,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] ram_wmask,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [15:0] BURST_CAP = 16'(MAX_BURST);

    state_t      state;
    state_t      state_next;
    logic        rr_ptr;
    logic        rr_next;
    logic [15:0] burst_cnt;
    logic [15:0] burst_next;
    logic [15:0] burst_inc;
    logic        rearbitrate;

    logic              accept;
    logic              sel1;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] cmd_wmask;

    logic ram_we_q;
    logic tag1_valid;
    logic tag1_port;
    logic tag2_valid;
    logic tag2_port;

    // Burst counter increments saturate so a long uncontested lock never wraps.
    assign burst_inc = (burst_cnt == 16'hFFFF) ? burst_cnt : burst_cnt + 16'd1;

    // Arbitration: rr_ptr = 1 means port 1 wins a tie.
    // Releasing ownership falls through to the idle arbitration in the same
    // cycle, so a release never costs a bubble. Every grant leaves rr_ptr
    // pointing at the other port, except a forced hand-over at the burst cap,
    // which points back at the port that was capped.
    always_comb begin
        state_next  = state;
        rr_next     = rr_ptr;
        burst_next  = burst_cnt;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        rearbitrate = 1'b0;

        case (state)
            IDLE: begin
                rearbitrate = 1'b1;
            end
            OWN0: begin
                if (!req0 || !lock0) begin
                    rearbitrate = 1'b1;
                end else if ((burst_cnt < BURST_CAP) || !req1) begin
                    gnt0       = 1'b1;
                    burst_next = burst_inc;
                    rr_next    = 1'b1;
                end else begin
                    gnt1    = 1'b1;
                    rr_next = 1'b0;
                    if (lock1) begin
                        state_next = OWN1;
                        burst_next = 16'd1;
                    end else begin
                        state_next = IDLE;
                        burst_next = 16'd0;
                    end
                end
            end
            OWN1: begin
                if (!req1 || !lock1) begin
                    rearbitrate = 1'b1;
                end else if ((burst_cnt < BURST_CAP) || !req0) begin
                    gnt1       = 1'b1;
                    burst_next = burst_inc;
                    rr_next    = 1'b0;
                end else begin
                    gnt0    = 1'b1;
                    rr_next = 1'b1;
                    if (lock0) begin
                        state_next = OWN0;
                        burst_next = 16'd1;
                    end else begin
                        state_next = IDLE;
                        burst_next = 16'd0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                burst_next = 16'd0;
            end
        endcase

        if (rearbitrate) begin
            state_next = IDLE;
            burst_next = 16'd0;
            if (req1 && (!req0 || rr_ptr)) begin
                gnt1    = 1'b1;
                rr_next = 1'b0;
                if (lock1) begin
                    state_next = OWN1;
                    burst_next = 16'd1;
                end
            end else if (req0) begin
                gnt0    = 1'b1;
                rr_next = 1'b1;
                if (lock0) begin
                    state_next = OWN0;
                    burst_next = 16'd1;
                end
            end
        end

        // Nothing is accepted while reset is being sampled.
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            burst_cnt <= 16'd0;
        end else begin
            state     <= state_next;
            rr_ptr    <= rr_next;
            burst_cnt <= burst_next;
        end
    end

    // Command mux from the granted port.
    assign accept    = gnt0 | gnt1;
    assign sel1      = gnt1;
    assign cmd_we    = sel1 ? we1    : we0;
    assign cmd_addr  = sel1 ? addr1  : addr0;
    assign cmd_wdata = sel1 ? wdata1 : wdata0;
    assign cmd_wmask = sel1 ? wmask1 : wmask0;

    // RAM port registers and read-return tag pipeline.
    // Address/data registers only load on an accept so idle cycles keep the
    // RAM inputs quiet; only the write enable drops back to 0.
    // The tag pipeline is {valid, port}; its second stage lines up with the
    // cycle in which ram_rdata carries the addressed word.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_we_q   <= 1'b0;
            ram_raddr  <= '0;
            ram_waddr  <= '0;
            ram_wdata  <= '0;
            ram_wmask  <= '0;
            tag1_valid <= 1'b0;
            tag1_port  <= 1'b0;
            tag2_valid <= 1'b0;
            tag2_port  <= 1'b0;
        end else begin
            ram_we_q   <= accept && cmd_we;
            tag1_valid <= accept && !cmd_we;
            tag1_port  <= sel1;
            tag2_valid <= tag1_valid;
            tag2_port  <= tag1_port;
            if (accept) begin
                ram_raddr <= cmd_addr;
                ram_waddr <= cmd_addr;
                ram_wdata <= cmd_wdata;
                ram_wmask <= cmd_wmask;
            end
        end
    end

    // A write that is registered but not yet committed when reset is sampled
    // must not reach the RAM, so the enable is masked by rst.
    assign ram_we = ram_we_q && !rst;

    assign rvalid0 = tag2_valid && !tag2_port;
    assign rvalid1 = tag2_valid &&  tag2_port;
    assign rdata0  = ram_rdata;
    assign rdata1  = ram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_port_arbiter
//
// Purpose:
//   Self-checking bench for sram_port_arbiter. A behavioural combined_ram
//   (masked write, registered read) is attached to the RAM ports. Read-only
//   arbitration traffic is driven from a table of vectors with hand-computed
//   expected outputs; bursts, writes and reset corner cases use short
//   hand-written sequences.
//
//   Unwritten RAM words read as (address ^ 16'hA5A5).
// ---------------------------------------------------------------------------
module tb_sram_port_arbiter;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0, lock0, we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0, wmask0;
    logic              req1, lock1, we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1, wmask1;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0] ram_raddr, ram_waddr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata, ram_wmask;
    logic [DATA_W-1:0] ram_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .lock0     (lock0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .wmask0    (wmask0),
        .req1      (req1),
        .lock1     (lock1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .wmask1    (wmask1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .ram_raddr (ram_raddr),
        .ram_waddr (ram_waddr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_wmask (ram_wmask),
        .ram_rdata (ram_rdata)
    );

    // Behavioural combined_ram: masked write, registered read.
    logic [DATA_W-1:0] mem     [0:(1<<ADDR_W)-1];
    bit                written [0:(1<<ADDR_W)-1];

    function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
        ram_word = written[a] ? mem[a] : (16'(a) ^ 16'hA5A5);
    endfunction

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr]     <= (ram_word(ram_waddr) & ram_wmask) | (ram_wdata & ~ram_wmask);
            written[ram_waddr] <= 1'b1;
        end
        ram_rdata <= ram_word(ram_raddr);
    end

    typedef struct {
        logic              rst;
        logic              req0;
        logic              lock0;
        logic [ADDR_W-1:0] addr0;
        logic              req1;
        logic              lock1;
        logic [ADDR_W-1:0] addr1;
        logic              e_gnt0;
        logic              e_gnt1;
        logic              e_rv0;
        logic              e_rv1;
        logic [DATA_W-1:0] e_rdata;
        logic [ADDR_W-1:0] e_raddr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int r, input int q0, input int l0, input int a0,
                                input int q1, input int l1, input int a1,
                                input int g0, input int g1, input int v0, input int v1,
                                input int rd, input int ra);
        vec_t v;
        v.rst     = 1'(r);
        v.req0    = 1'(q0);
        v.lock0   = 1'(l0);
        v.addr0   = 13'(a0);
        v.req1    = 1'(q1);
        v.lock1   = 1'(l1);
        v.addr1   = 13'(a1);
        v.e_gnt0  = 1'(g0);
        v.e_gnt1  = 1'(g1);
        v.e_rv0   = 1'(v0);
        v.e_rv1   = 1'(v1);
        v.e_rdata = 16'(rd);
        v.e_raddr = 13'(ra);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst    = v.rst;
        req0   = v.req0;
        lock0  = v.lock0;
        we0    = 1'b0;
        addr0  = v.addr0;
        wdata0 = '0;
        wmask0 = '0;
        req1   = v.req1;
        lock1  = v.lock1;
        we1    = 1'b0;
        addr1  = v.addr1;
        wdata1 = '0;
        wmask1 = '0;
    endtask

    task automatic set_p0(input int r, input int l, input int w, input int a,
                          input int d, input int m);
        req0 = 1'(r); lock0 = 1'(l); we0 = 1'(w);
        addr0 = 13'(a); wdata0 = 16'(d); wmask0 = 16'(m);
    endtask

    task automatic set_p1(input int r, input int l, input int w, input int a,
                          input int d, input int m);
        req1 = 1'(r); lock1 = 1'(l); we1 = 1'(w);
        addr1 = 13'(a); wdata1 = 16'(d); wmask1 = 16'(m);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, " rvalid0"},   32'(rvalid0),   32'h0);
        checkOutput({tag, " rvalid1"},   32'(rvalid1),   32'h0);
        checkOutput({tag, " ram_we"},    32'(ram_we),    32'h0);
        checkOutput({tag, " ram_raddr"}, 32'(ram_raddr), 32'h0);
        checkOutput({tag, " ram_waddr"}, 32'(ram_waddr), 32'h0);
        checkOutput({tag, " ram_wdata"}, 32'(ram_wdata), 32'h0);
        checkOutput({tag, " ram_wmask"}, 32'(ram_wmask), 32'h0);
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1;
        set_p0(0, 0, 0, 0, 0, 0);
        set_p1(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        checkOutput("reset gnt0", 32'(gnt0), 32'h0);
        checkOutput("reset gnt1", 32'(gnt1), 32'h0);
        check_all_zero("reset");
        next_cycle();

        // Contention, mid-run reset, single reads, lock release without bubble.
        tbl.push_back(mk(0, 1,0,'h10,   1,0,'h20,   1,0, 0,0, 0,       'h000));
        tbl.push_back(mk(0, 1,0,'h10,   1,0,'h20,   0,1, 0,0, 0,       'h010));
        tbl.push_back(mk(0, 1,0,'h10,   1,0,'h20,   1,0, 1,0, 'hA5B5,  'h020));
        tbl.push_back(mk(0, 1,0,'h10,   1,0,'h20,   0,1, 0,1, 'hA585,  'h010));
        tbl.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 1,0, 'hA5B5,  'h020));
        tbl.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 0,1, 'hA585,  'h020));
        tbl.push_back(mk(1, 0,0,0,      0,0,0,      0,0, 0,0, 0,       'h020));
        tbl.push_back(mk(0, 1,0,'h5,    0,0,0,      1,0, 0,0, 0,       'h000));
        tbl.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 0,0, 0,       'h005));
        tbl.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 1,0, 'hA5A0,  'h005));
        tbl.push_back(mk(0, 0,0,0,      1,0,'hABC,  0,1, 0,0, 0,       'h005));
        tbl.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 0,0, 0,       'hABC));
        tbl.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 0,1, 'hAF19,  'hABC));
        tbl.push_back(mk(0, 1,1,'h5,    1,0,'hABC,  1,0, 0,0, 0,       'hABC));
        tbl.push_back(mk(0, 1,0,'h10,   1,0,'hABC,  0,1, 0,0, 0,       'h005));
        tbl.push_back(mk(0, 1,0,'h10,   0,0,0,      1,0, 1,0, 'hA5A0,  'hABC));
        tbl.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 0,1, 'hAF19,  'h010));
        tbl.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 1,0, 'hA5B5,  'h010));
        tbl.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 0,0, 0,       'h010));

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d gnt0", i),    32'(gnt0),    32'(tbl[i].e_gnt0));
            checkOutput($sformatf("vec%0d gnt1", i),    32'(gnt1),    32'(tbl[i].e_gnt1));
            checkOutput($sformatf("vec%0d rvalid0", i), 32'(rvalid0), 32'(tbl[i].e_rv0));
            checkOutput($sformatf("vec%0d rvalid1", i), 32'(rvalid1), 32'(tbl[i].e_rv1));
            if (tbl[i].e_rv0)
                checkOutput($sformatf("vec%0d rdata0", i), 32'(rdata0), 32'(tbl[i].e_rdata));
            if (tbl[i].e_rv1)
                checkOutput($sformatf("vec%0d rdata1", i), 32'(rdata1), 32'(tbl[i].e_rdata));
            checkOutput($sformatf("vec%0d ram_we", i),    32'(ram_we),    32'h0);
            checkOutput($sformatf("vec%0d ram_raddr", i), 32'(ram_raddr), 32'(tbl[i].e_raddr));
            next_cycle();
        end
        rst = 1'b0;
        set_p0(0, 0, 0, 0, 0, 0);
        set_p1(0, 0, 0, 0, 0, 0);

        // Locked burst on port 0, port 1 requesting from cycle 2: eight port-0
        // grants, one port-1 grant, then port 0 again.
        for (int c = 0; c <= 11; c++) begin
            set_p0((c <= 9) ? 1 : 0, 1, 0, 'h5, 0, 0);
            set_p1((c >= 2 && c <= 8) ? 1 : 0, 0, 0, 'h20, 0, 0);
            @(negedge clk);
            checkOutput($sformatf("burst c%0d gnt0", c), 32'(gnt0), (c <= 7 || c == 9) ? 32'h1 : 32'h0);
            checkOutput($sformatf("burst c%0d gnt1", c), 32'(gnt1), (c == 8) ? 32'h1 : 32'h0);
            if (c == 10) begin
                checkOutput("burst rvalid1", 32'(rvalid1), 32'h1);
                checkOutput("burst rdata1",  32'(rdata1),  32'hA585);
                checkOutput("burst rvalid0 gap", 32'(rvalid0), 32'h0);
            end
            if (c == 11) begin
                checkOutput("burst rvalid0 resume", 32'(rvalid0), 32'h1);
                checkOutput("burst rvalid1 single", 32'(rvalid1), 32'h0);
            end
            next_cycle();
        end

        // Port 1 write then immediate read of the same address.
        set_p1(1, 0, 1, 'h1FFF, 'hBEEF, 'h0000);
        @(negedge clk);
        checkOutput("wr gnt1", 32'(gnt1), 32'h1);
        checkOutput("wr ram_we idle", 32'(ram_we), 32'h0);
        next_cycle();
        set_p1(1, 0, 0, 'h1FFF, 0, 0);
        @(negedge clk);
        checkOutput("rd gnt1", 32'(gnt1), 32'h1);
        checkOutput("wr ram_we", 32'(ram_we), 32'h1);
        checkOutput("wr ram_waddr", 32'(ram_waddr), 32'h1FFF);
        checkOutput("wr ram_wdata", 32'(ram_wdata), 32'hBEEF);
        checkOutput("wr ram_wmask", 32'(ram_wmask), 32'h0000);
        next_cycle();
        set_p1(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("wr ram_we once", 32'(ram_we), 32'h0);
        checkOutput("wr no rvalid1", 32'(rvalid1), 32'h0);
        checkOutput("rd ram_raddr", 32'(ram_raddr), 32'h1FFF);
        next_cycle();
        @(negedge clk);
        checkOutput("rd rvalid1", 32'(rvalid1), 32'h1);
        checkOutput("rd rdata1",  32'(rdata1),  32'hBEEF);
        next_cycle();

        // Masked write on port 0.
        set_p0(1, 0, 1, 'h3, 'hFFFF, 'h0000);
        @(negedge clk);
        checkOutput("mask gnt0 a", 32'(gnt0), 32'h1);
        next_cycle();
        set_p0(1, 0, 1, 'h3, 'h0000, 'hFF00);
        @(negedge clk);
        checkOutput("mask ram_wdata a", 32'(ram_wdata), 32'hFFFF);
        next_cycle();
        set_p0(1, 0, 0, 'h3, 0, 0);
        @(negedge clk);
        checkOutput("mask ram_wmask b", 32'(ram_wmask), 32'hFF00);
        checkOutput("mask ram_we b", 32'(ram_we), 32'h1);
        next_cycle();
        set_p0(0, 0, 0, 0, 0, 0);
        next_cycle();
        @(negedge clk);
        checkOutput("mask rvalid0", 32'(rvalid0), 32'h1);
        checkOutput("mask rdata0",  32'(rdata0),  32'hFF00);
        next_cycle();

        // Reset one cycle after a read is accepted.
        set_p0(1, 0, 0, 'h5, 0, 0);
        @(negedge clk);
        checkOutput("rstrd gnt0", 32'(gnt0), 32'h1);
        next_cycle();
        set_p0(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("rstrd");
        next_cycle();
        set_p0(1, 0, 0, 'h5, 0, 0);
        set_p1(1, 0, 0, 'h7, 0, 0);
        @(negedge clk);
        checkOutput("rstrd rr gnt0", 32'(gnt0), 32'h1);
        checkOutput("rstrd rr gnt1", 32'(gnt1), 32'h0);
        next_cycle();
        set_p0(0, 0, 0, 0, 0, 0);
        set_p1(0, 0, 0, 0, 0, 0);
        next_cycle();

        // Reset while a registered write is pending: the write must not land.
        set_p1(1, 0, 1, 'h7, 'h1234, 'h0000);
        @(negedge clk);
        checkOutput("rstwr gnt1", 32'(gnt1), 32'h1);
        next_cycle();
        set_p1(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstwr ram_we cancelled", 32'(ram_we), 32'h0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        set_p1(1, 0, 0, 'h7, 0, 0);
        @(negedge clk);
        checkOutput("rstwr rd gnt1", 32'(gnt1), 32'h1);
        next_cycle();
        set_p1(0, 0, 0, 0, 0, 0);
        next_cycle();
        @(negedge clk);
        checkOutput("rstwr rvalid1", 32'(rvalid1), 32'h1);
        checkOutput("rstwr rdata1",  32'(rdata1),  32'hA5A2);
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
